// File: rtl/req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// req_arb_pkg
// Shared definitions for the request arbiter and its round-robin picker:
//   - arb_state_t / ST_IDLE / ST_OFFER : grant FSM state encoding
//   - NREQ_DEF     : default number of request sources
//   - IDX_W_DEF    : index width for the default source count
//   - DROP_W_DEF   : default width of the saturating drop counter
//   - DROP_SAT_DEF : saturation value of the default-width drop counter
//   - idx_width()  : index width helper, never returns zero
// ---------------------------------------------------------------------------
package req_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int IDX_W_DEF  = $clog2(NREQ_DEF);
    localparam int DROP_W_DEF = 8;
    localparam logic [DROP_W_DEF-1:0] DROP_SAT_DEF = '1;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_OFFER = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Scans pending starting at ptr
// and wrapping modulo NREQ; reports the first set bit.
//   pending [NREQ] in  : candidate bits
//   ptr     [IW]   in  : highest-priority position (must be < NREQ)
//   any            out : at least one pending bit is set
//   idx     [IW]   out : index of the chosen bit (0 when any is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest position back to ptr so the last hit written
    // is the one closest to ptr in round-robin order.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (pending[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter
// Holds single-cycle request events as sticky pending bits and serves them
// one at a time with a round-robin grant over a valid/ready handshake.
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset, clears all state
//   req_in     in  : request events, a high bit marks that source pending
//   gnt_ready  in  : consumer accepts the offered grant
//   gnt_valid  out : a grant is offered (registered state decode)
//   gnt_idx    out : granted source, stable while gnt_valid is high
//   pending    out : current sticky pending bits
//   drop_cnt   out : saturating count of requests merged into an already
//                    pending bit; only with REQ_ARB_DROP_CNT_EN defined
// Every handshake is followed by one IDLE cycle, so peak rate is one grant
// per two cycles.
// ---------------------------------------------------------------------------
module req_arbiter
    import req_arb_pkg::*;
#(
    parameter  int NREQ   = NREQ_DEF,
    parameter  int DROP_W = DROP_W_DEF,
    localparam int IW     = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_in,
    input  logic              gnt_ready,
    output logic              gnt_valid,
    output logic [IW-1:0]     gnt_idx,
    output logic [NREQ-1:0]   pending
`ifdef REQ_ARB_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] clr;
    logic            handshake;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    always_comb begin
        handshake = (state_q == ST_OFFER) && gnt_ready;
        clr       = '0;
        if (handshake) begin
            clr[gnt_idx_q] = 1'b1;
        end
        // OR-ing req_in after the clear lets a same-cycle re-request survive.
        pending_d = (pending_q & ~clr) | req_in;

        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_idx_d = pick_idx;
                    state_d   = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (gnt_ready) begin
                    ptr_d   = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            pending_q <= pending_d;
        end
    end

    assign gnt_valid = (state_q == ST_OFFER);
    assign gnt_idx   = gnt_idx_q;
    assign pending   = pending_q;

`ifdef REQ_ARB_DROP_CNT_EN
    localparam logic [DROP_W-1:0] DROP_SAT = '1;

    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [NREQ-1:0]   drop_hits;
    logic [IW:0]       drop_inc;
    logic [DROP_W:0]   drop_sum;

    // One extra sum bit exposes overflow so the counter clamps, never wraps.
    always_comb begin
        drop_hits = req_in & pending_q & ~clr;
        drop_inc  = '0;
        for (int i = 0; i < NREQ; i++) begin
            drop_inc = drop_inc + (IW + 1)'(drop_hits[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_W + 1)'(drop_inc);
        drop_cnt_d = (drop_sum > {1'b0, DROP_SAT}) ? DROP_SAT : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Keeps the counter width parameter referenced when the counter is absent.
    logic [DROP_W-1:0] unused_drop_w;
    assign unused_drop_w = '0;
`endif

endmodule

// File: tb/tb_req_arbiter.sv
module tb_req_arbiter;
    import req_arb_pkg::*;

    localparam int N = NREQ_DEF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_in;
    logic                 gnt_ready;
    logic                 gnt_valid;
    logic [IDX_W_DEF-1:0] gnt_idx;
    logic [N-1:0]         pending;
`ifdef REQ_ARB_DROP_CNT_EN
    logic [DROP_W_DEF-1:0] drop_cnt;
`endif

    req_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .pending   (pending)
`ifdef REQ_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pend;
        logic         vld;
        int           drop;
    } exp_t;

    exp_t pq[$];   // per-edge expected state
    int   gq[$];   // expected grant indices, in order of offer

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a set of pending sources, a "busy serving" flag and
    // the next-favoured source number.
    bit m_pend[N];
    bit m_busy;
    int m_cur;
    int m_next;
    int m_drop;
    int sat_max = int'(DROP_SAT_DEF);

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rdy, input logic rs);
        exp_t e;
        int   cleared;
        if (rs) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_busy = 1'b0;
            m_cur  = 0;
            m_next = 0;
            m_drop = 0;
        end else begin
            cleared = (m_busy && rdy) ? m_cur : -1;
            for (int i = 0; i < N; i++) begin
                if (r[i] && m_pend[i] && i != cleared && m_drop < sat_max) m_drop++;
            end
            if (cleared >= 0) begin
                m_pend[cleared] = 1'b0;
                m_next = (cleared + 1) % N;
                m_busy = 1'b0;
            end else if (!m_busy) begin
                for (int d = 0; d < N; d++) begin
                    if (!m_busy && m_pend[(m_next + d) % N]) begin
                        m_busy = 1'b1;
                        m_cur  = (m_next + d) % N;
                        gq.push_back(m_cur);
                    end
                end
            end
            for (int i = 0; i < N; i++) if (r[i]) m_pend[i] = 1'b1;
        end
        for (int i = 0; i < N; i++) e.pend[i] = m_pend[i];
        e.vld  = m_busy;
        e.drop = m_drop;
        pq.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic rdy, input logic rs);
        req_in    = r;
        gnt_ready = rdy;
        rst       = rs;
        model_step(r, rdy, rs);
        @(negedge clk);
    endtask

    // Monitor: samples just after each rising edge.
    initial begin : monitor
        exp_t         e;
        logic         prev_vld;
        logic [IDX_W_DEF-1:0] prev_idx;
        prev_vld = 1'b0;
        prev_idx = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pq.size() != 0) begin
                e = pq.pop_front();
                check("pending", int'(pending), int'(e.pend));
                check("gnt_valid", int'(gnt_valid), int'(e.vld));
`ifdef REQ_ARB_DROP_CNT_EN
                check("drop_cnt", int'(drop_cnt), e.drop);
`endif
                if (rst) begin
                    check("gnt_idx_after_reset", int'(gnt_idx), 0);
                end else if (gnt_valid && !prev_vld) begin
                    if (gq.size() == 0) begin
                        check("unexpected_grant", int'(gnt_idx), -1);
                    end else begin
                        check("gnt_idx", int'(gnt_idx), gq.pop_front());
                    end
                end else if (gnt_valid && prev_vld) begin
                    check("gnt_idx_stable", int'(gnt_idx), int'(prev_idx));
                end
                prev_vld = gnt_valid;
                prev_idx = gnt_idx;
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] r;
        logic         rdy;
        logic         rs;
        m_busy = 1'b0; m_cur = 0; m_next = 0; m_drop = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;

        // Reset with all requests asserted
        for (int i = 0; i < 3; i++) drive(4'b1111, 1'b0, 1'b1);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);

        // Single request, consumer always ready
        drive(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(4'b0000, 1'b1, 1'b0);

        // Round-robin with everything pending
        drive(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) drive(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(4'b0000, 1'b1, 1'b0);

        // Backpressure on grant 1 while source 3 pulses
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive((i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(4'b0000, 1'b1, 1'b0);

        // Clear and re-request in the handshake cycle
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0111, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(4'b0000, 1'b1, 1'b0);

`ifdef REQ_ARB_DROP_CNT_EN
        // Drop counter saturation, then reset
        drive(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 301; i++) drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b1, 1'b0);
`endif

        // Randomised traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            r   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 199) == 0);
            drive(r, rdy, rs);
        end

        // Drain
        for (int i = 0; i < 12; i++) drive(4'b0000, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("grants_left", gq.size(), 0);
        check("records_left", pq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Collects single-cycle request events from up to four `req_singleshot` instances and holds each one as a sticky pending bit. Serves the pending bits one at a time with a round-robin grant. Each grant uses a valid/ready handshake towards the downstream consumer, so no request event is lost while the consumer is busy. Sits directly downstream of the request single-shot stage and upstream of the shared resource it protects.

## Interface
- `NREQ`, 4, number of request sources (design and verification target is 4; index width is `$clog2(NREQ)`)
- `DROP_W`, 8, width of the saturating drop counter (only used when the counter is compiled in)

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_in`  in  NREQ  request events; a high bit in any cycle marks that source pending
- `gnt_ready`  in  1  consumer accepts the offered grant this cycle
- `gnt_valid`  out  1  a grant is being offered
- `gnt_idx`  out  $clog2(NREQ)  index of the granted source; stable while `gnt_valid` is high
- `pending`  out  NREQ  current sticky pending bits
- `drop_cnt`  out  DROP_W  count of request events merged into an already-pending bit (present only with `REQ_ARB_DROP_CNT_EN`)

## Operation
- Reset (`rst` high at a clock edge) has priority over every other input and clears all state:
  - `pending` = 0, round-robin pointer `ptr` = 0, state = IDLE
  - `gnt_valid` = 0, `gnt_idx` = 0, `drop_cnt` = 0
- Reset during OFFER abandons the grant. No pending bit survives reset.
- Pending update each cycle: `pending_next = (pending & ~clr) | req_in`.
  - `clr` is a one-hot of `gnt_idx` in the cycle the handshake completes, otherwise 0.
  - A new request on the source being cleared in the same cycle wins, so that bit stays set.
- States:
  - IDLE:
    - If `pending` (registered value) is nonzero, the round-robin pick chooses the first set bit scanning `ptr`, `ptr+1`, … with wrap modulo NREQ.
    - The pick is latched into `gnt_idx` and the state moves to OFFER.
    - Otherwise the block stays in IDLE.
  - OFFER:
    - `gnt_valid` = 1.
    - When `gnt_ready` = 1, the handshake completes: clear `pending[gnt_idx]`, set `ptr <= gnt_idx + 1` (wraps to 0 after NREQ-1), return to IDLE.
    - When `gnt_ready` = 0, hold `gnt_idx` and stay in OFFER indefinitely.
- `gnt_valid` is a registered state decode. It is high exactly in OFFER.
- `gnt_ready` is ignored outside OFFER.
- Requests arriving during OFFER only set pending bits. They never change `gnt_idx`.

## Timing
- Latency: `req_in[i]` high at edge t → `pending[i]` = 1 after t → `gnt_valid` = 1 after t+1 (when the block is idle and source i is picked).
- Handshake completes at the edge where `gnt_valid & gnt_ready`. `gnt_valid` is 0 in the following cycle (mandatory IDLE bubble).
- Peak throughput: one grant every 2 cycles.
- Fairness: with all sources continuously pending, grants follow the order 0,1,2,3,0,…
- No combinational path from any input to any output.

## Configuration
- `REQ_ARB_DROP_CNT_EN` defined:
  - `drop_cnt` port and register exist.
  - Each cycle, add the number of bits set in `req_in & pending & ~clr`.
  - Saturate at 2^DROP_W − 1. Never wrap.
- Not defined:
  - Port and register are absent.
  - All other behaviour is identical.

## Structure
- Package `req_arb_pkg` holds:
  - state typedef (IDLE, OFFER)
  - `NREQ_DEF` = 4
  - index-width constant
  - drop-counter saturation constant
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `pending`, `ptr`.
  - Outputs: `any`, `idx`.
  - Reused by other arbiters in the design.

## Test plan
- Reset: drive `req_in`=4'b1111 with `rst`=1 → after release, `pending`=0 and `gnt_valid`=0; first grant `gnt_idx`=0.
- Single request, consumer always ready: pulse `req_in`=4'b0100 at cycle 0 → `gnt_valid`=1, `gnt_idx`=2 at cycle 2; `pending`=0 after the handshake.
- Round-robin: hold all four pending, `gnt_ready`=1 → grant sequence 0,1,2,3,0 with `gnt_valid` low every other cycle.
- Backpressure: grant idx 1 offered, `gnt_ready`=0 for 5 cycles while `req_in`=4'b1000 pulses → `gnt_idx` stays 1 and `pending`=4'b1010; after ready the next grant is 3.
- Simultaneous clear and re-request: `req_in[gnt_idx]` pulses in the handshake cycle → that bit stays pending and is re-granted after the other pending sources in round-robin order.
- With `REQ_ARB_DROP_CNT_EN`: 300 pulses on source 0 while `gnt_ready`=0 → `drop_cnt`=255 (saturated); reset → 0.
